// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming 3x3 window generator for the float conv datapath
//
// Purpose:
//   Accepts a raster-order pixel stream and buffers the two previous image
//   rows. For every interior pixel (row >= 2, col >= 2) it presents the 3x3
//   neighbourhood on data_out0..data_out8 with a one-cycle valid_out strobe.
//   "Valid" convolution: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
//   Pixel words are opaque bits and are never interpreted.
//
// Parameters:
//   DATA_WIDTH  pixel word width
//   IMG_WIDTH   pixels per row   (>= 3)
//   IMG_HEIGHT  rows per frame   (>= 3)
//
// Ports:
//   clk                   rising-edge clock
//   rst                   synchronous active-high reset
//   data_in   [DW-1:0]    pixel, raster order
//   valid_in              data_in accepted on this edge (no backpressure)
//   data_out0..8 [DW-1:0] window, row-major; 0 = top-left, 8 = newest pixel
//   valid_out             one-cycle strobe: window complete
//   frame_done            one-cycle strobe with the last window of a frame
//                         (present only with CONV_WINDOW_FRAME_DONE_EN)
//
// Configuration macro:
//   CONV_WINDOW_FRAME_DONE_EN  adds the frame_done output and its logic.

module conv_window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic [DATA_WIDTH-1:0] data_out3,
  output logic [DATA_WIDTH-1:0] data_out4,
  output logic [DATA_WIDTH-1:0] data_out5,
  output logic [DATA_WIDTH-1:0] data_out6,
  output logic [DATA_WIDTH-1:0] data_out7,
  output logic [DATA_WIDTH-1:0] data_out8,
`ifdef CONV_WINDOW_FRAME_DONE_EN
  output logic                  frame_done,
`endif
  output logic                  valid_out
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  // Position of the pixel currently on data_in within the frame.
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Reset has priority: a pixel presented together with rst is dropped.
  logic accept;
  logic col_wrap;
  logic row_wrap;
  logic window_hit;

  assign accept     = valid_in && !rst;
  assign col_wrap   = (col == COL_LAST);
  assign row_wrap   = (row == ROW_LAST);
  // Column-edge positions never form a window, so no window straddles rows.
  assign window_hit = accept && (row >= ROW_TWO) && (col >= COL_TWO);

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        // Wrapping at the last pixel lets the next frame follow with no idle.
        if (row_wrap) begin
          row <= '0;
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers
  //   lb0[c] holds row r-1, lb1[c] holds row r-2. Contents are not reset:
  //   after a reset row restarts at 0, so rows 0 and 1 overwrite every entry
  //   before the first window can read them.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

  logic [DATA_WIDTH-1:0] tap_top;
  logic [DATA_WIDTH-1:0] tap_mid;
  logic [DATA_WIDTH-1:0] tap_bot;

  // Taps are read before this edge's write to the same index lands.
  assign tap_top = lb1[col];
  assign tap_mid = lb0[col];
  assign tap_bot = data_in;

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // 3x3 window register array, row-major: win[0..2] top row, win[6..8]
  // bottom row. On accept each row shifts left and loads its tap at the right.
  // Gaps leave the array untouched so the outputs hold.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] win [9];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        win[i] <= '0;
      end
    end else if (accept) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= tap_top;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= tap_mid;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= tap_bot;
    end
  end

  assign data_out0 = win[0];
  assign data_out1 = win[1];
  assign data_out2 = win[2];
  assign data_out3 = win[3];
  assign data_out4 = win[4];
  assign data_out5 = win[5];
  assign data_out6 = win[6];
  assign data_out7 = win[7];
  assign data_out8 = win[8];

  // ---------------------------------------------------------------------------
  // Valid strobe: registered alongside the window it qualifies.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= window_hit;
    end
  end

`ifdef CONV_WINDOW_FRAME_DONE_EN
  // Last pixel of the frame is always an interior position, so this strobe
  // coincides with the final valid_out of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && col_wrap && row_wrap;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - randomized self-checking bench for conv_window_gen

module tb_conv_window_gen;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_out0, data_out1, data_out2, data_out3, data_out4;
  logic [DW-1:0] data_out5, data_out6, data_out7, data_out8;
  logic          valid_out;
`ifdef CONV_WINDOW_FRAME_DONE_EN
  logic          frame_done;
`endif

  always #5 clk = ~clk;

  conv_window_gen #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .data_out3  (data_out3),
    .data_out4  (data_out4),
    .data_out5  (data_out5),
    .data_out6  (data_out6),
    .data_out7  (data_out7),
    .data_out8  (data_out8),
`ifdef CONV_WINDOW_FRAME_DONE_EN
    .frame_done (frame_done),
`endif
    .valid_out  (valid_out)
  );

  logic [DW-1:0] dout [9];
  assign dout[0] = data_out0;
  assign dout[1] = data_out1;
  assign dout[2] = data_out2;
  assign dout[3] = data_out3;
  assign dout[4] = data_out4;
  assign dout[5] = data_out5;
  assign dout[6] = data_out6;
  assign dout[7] = data_out7;
  assign dout[8] = data_out8;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference model: the current frame as a 2-D image plus a pixel count.
  // A window after pixel (r,c) is simply img[r-2..r][c-2..c].
  logic [DW-1:0] img [H][W];
  int            pos       = 0;
  logic          exp_valid = 1'b0;
  logic          exp_fd    = 1'b0;
  logic [DW-1:0] exp_win [9];
  bit            win_def   = 1'b0;   // exp_win describes the DUT outputs
  int            valid_seen = 0;

  task automatic cycle(input logic r, input logic v, input logic [DW-1:0] d);
    int pr;
    int pc;
    @(negedge clk);
    rst      = r;
    valid_in = v;
    data_in  = d;
    if (r) begin
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
      pos       = 0;
      win_def   = 1'b1;
      for (int k = 0; k < 9; k++) exp_win[k] = '0;
    end else if (v) begin
      pr = pos / W;
      pc = pos % W;
      img[pr][pc] = d;
      exp_valid = (pr >= 2) && (pc >= 2);
      exp_fd    = (pr == H - 1) && (pc == W - 1);
      if (exp_valid) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[i*3+j] = img[pr-2+i][pc-2+j];
        win_def = 1'b1;
      end else begin
        win_def = 1'b0;   // edge-column shift: contents unspecified
      end
      pos = (pos + 1) % (W * H);
    end else begin
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
    end
    @(posedge clk);
    #1;
    check("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
`ifdef CONV_WINDOW_FRAME_DONE_EN
    check("frame_done", {31'b0, frame_done}, {31'b0, exp_fd});
`endif
    if (win_def)
      for (int k = 0; k < 9; k++) check($sformatf("data_out%0d", k), dout[k], exp_win[k]);
    if (valid_out === 1'b1) valid_seen++;
  endtask

  task automatic check_const_win(input string tag, input int base, input int a, input int b);
    // window rows start at base, base+W, base+2W; a/b unused offsets kept 0
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        check($sformatf("%s[%0d]", tag, i*3+j), dout[i*3+j], DW'(base + a + b + i*W + j));
  endtask

  initial begin
    // Reset state
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);

    // 1: full-rate frame
    valid_seen = 0;
    for (int p = 0; p < 16; p++) begin
      cycle(1'b0, 1'b1, DW'(p));
      if (p == 10) check_const_win("s1_first", 0, 0, 0);
      if (p == 15) check_const_win("s1_last", 5, 0, 0);
    end
    check("s1_windows", DW'(valid_seen), DW'(4));

    // 2: gapped input
    cycle(1'b1, 1'b0, '0);
    valid_seen = 0;
    for (int p = 0; p < 16; p++) begin
      cycle(1'b0, 1'b1, DW'(p));
      cycle(1'b0, 1'b0, 32'hDEAD_BEEF);
    end
    check("s2_windows", DW'(valid_seen), DW'(4));

    // 3: back-to-back frames
    cycle(1'b1, 1'b0, '0);
    valid_seen = 0;
    for (int p = 0; p < 16; p++) cycle(1'b0, 1'b1, DW'(p));
    for (int p = 0; p < 16; p++) begin
      cycle(1'b0, 1'b1, DW'(100 + p));
      if (p == 10) check_const_win("s3_first", 100, 0, 0);
    end
    check("s3_windows", DW'(valid_seen), DW'(8));

    // 4: reset mid-frame
    for (int p = 0; p < 10; p++) cycle(1'b0, 1'b1, DW'(p));
    cycle(1'b1, 1'b0, '0);
    valid_seen = 0;
    for (int p = 0; p < 16; p++) begin
      cycle(1'b0, 1'b1, DW'(200 + p));
      if (p == 10) check_const_win("s4_first", 200, 0, 0);
    end
    check("s4_windows", DW'(valid_seen), DW'(4));

    // 5: reset together with a valid pixel
    for (int p = 0; p < 5; p++) cycle(1'b0, 1'b1, DW'(50 + p));
    cycle(1'b1, 1'b1, DW'(7));
    valid_seen = 0;
    for (int p = 0; p < 16; p++) begin
      cycle(1'b0, 1'b1, DW'(300 + p));
      if (p == 10) check_const_win("s5_first", 300, 0, 0);
    end
    check("s5_windows", DW'(valid_seen), DW'(4));

    // Randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), DW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
